// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction-side fetch path.
// Holds the opcode constants the sequencer recognises, the fetch FSM state
// encoding and the default program-address width.
package cpu_pkg;

   localparam int ADDR_W = 6;

   localparam logic [7:0] OP_NOP  = 8'h00;
   localparam logic [7:0] OP_LDI  = 8'h10;
   localparam logic [7:0] OP_JMP  = 8'h20;
   localparam logic [7:0] OP_JMPC = 8'h21;
   localparam logic [7:0] OP_HALT = 8'hFF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle of loader, decoder-feedback and instruction signals around the
// fetch unit.
//   master : the side that feeds bytes / jump requests and consumes inst
//   slave  : the fetch unit itself
// Signals:
//   ld_valid/ld_data/ld_ready  byte-serial program loader (MSB byte first)
//   start                      begin execution at address 0
//   jmp_sig/jmp_sig_c/jmp_add  decoder jump requests and target
//   flag                       ALU compare result for conditional jumps
//   inst/pc                    current instruction word and its address
//   running/halted             FSM status
//   words_loaded               completed words since last load restart
interface fetch_unit_if #(
   parameter int ADDR_W = cpu_pkg::ADDR_W
);
   logic              ld_valid;
   logic [7:0]        ld_data;
   logic              ld_ready;
   logic              start;
   logic              jmp_sig;
   logic              jmp_sig_c;
   logic [ADDR_W-1:0] jmp_add;
   logic              flag;
   logic [31:0]       inst;
   logic [ADDR_W-1:0] pc;
   logic              running;
   logic              halted;
   logic [ADDR_W:0]   words_loaded;

   modport master (
      output ld_valid, ld_data, start, jmp_sig, jmp_sig_c, jmp_add, flag,
      input  ld_ready, inst, pc, running, halted, words_loaded
   );

   modport slave (
      input  ld_valid, ld_data, start, jmp_sig, jmp_sig_c, jmp_add, flag,
      output ld_ready, inst, pc, running, halted, words_loaded
   );
endinterface

// File: rtl/fetch_unit_prog_mem.sv
// Program memory: DEPTH x 32 words, one synchronous write port and one
// asynchronous read port. Contents survive reset on purpose so a loaded
// program can be rerun after rst.
// Ports:
//   clk    write clock
//   we     write enable
//   waddr  write address
//   wdata  write data
//   raddr  read address
//   rdata  read data (combinational)
module prog_mem #(
   parameter int ADDR_W = 6,
   parameter int DEPTH  = 2**ADDR_W
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [31:0]       wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [31:0]       rdata
);

   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_unit.sv
// Fetch unit: owns program memory and the PC, presents one registered
// instruction word per clock to the decoder, selects the next PC from the
// decoder's jump requests and the ALU flag, and fills memory through a
// byte-serial loader while idle.
// Ports:
//   clk  system clock (rising edge)
//   rst  asynchronous active-high reset
//   bus  fetch_unit_if.slave: loader, jump inputs, inst/pc/status outputs
module fetch_unit #(
   parameter int ADDR_W = cpu_pkg::ADDR_W,
   parameter int DEPTH  = 2**ADDR_W
) (
   input  logic         clk,
   input  logic         rst,
   fetch_unit_if.slave  bus
);
   import cpu_pkg::*;

   localparam logic [ADDR_W:0] WORDS_MAX = (ADDR_W+1)'(DEPTH);

   state_t            state_reg, state_next;
   logic [ADDR_W-1:0] pc_reg, pc_next;
   logic [31:0]       inst_reg, inst_next;
   logic [23:0]       asm_reg, asm_next;
   logic [1:0]        byte_cnt_reg, byte_cnt_next;
   logic [ADDR_W-1:0] wr_addr_reg, wr_addr_next;
   logic [ADDR_W:0]   words_loaded_reg, words_loaded_next;

   logic [ADDR_W-1:0] next_pc;
   logic [ADDR_W-1:0] rd_addr;
   logic [31:0]       rd_data;
   logic              mem_we;
   logic [31:0]       mem_wdata;
   logic              ld_ready;
   logic              accept;

   // start wins over a loader byte, so the loader stalls while start is high.
   assign ld_ready = (state_reg != RUN) && !bus.start;
   assign accept   = ld_ready && bus.ld_valid;

   // DEPTH is a power of two, so pc+1 wraps naturally.
   always_comb begin
      next_pc = pc_reg + 1'b1;
      if (bus.jmp_sig || (bus.jmp_sig_c && bus.flag)) begin
         next_pc = bus.jmp_add;
      end
   end

   // Outside RUN the only read needed is address 0 for a start request.
   assign rd_addr   = (state_reg == RUN) ? next_pc : '0;
   assign mem_wdata = {asm_reg, bus.ld_data};

   prog_mem #(
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_prog_mem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (wr_addr_reg),
      .wdata (mem_wdata),
      .raddr (rd_addr),
      .rdata (rd_data)
   );

   always_comb begin
      state_next        = state_reg;
      pc_next           = pc_reg;
      inst_next         = inst_reg;
      asm_next          = asm_reg;
      byte_cnt_next     = byte_cnt_reg;
      wr_addr_next      = wr_addr_reg;
      words_loaded_next = words_loaded_reg;
      mem_we            = 1'b0;

      case (state_reg)
         IDLE, HALT: begin
            if (bus.start) begin
               // Any partially assembled word is dropped.
               state_next    = RUN;
               pc_next       = '0;
               inst_next     = rd_data;
               asm_next      = '0;
               byte_cnt_next = '0;
            end else if (accept) begin
               if (state_reg == HALT) begin
                  // A byte while halted restarts loading from word 0.
                  state_next        = IDLE;
                  asm_next          = {16'h0000, bus.ld_data};
                  byte_cnt_next     = 2'd1;
                  wr_addr_next      = '0;
                  words_loaded_next = '0;
               end else if (byte_cnt_reg == 2'd3) begin
                  mem_we        = 1'b1;
                  wr_addr_next  = wr_addr_reg + 1'b1;
                  byte_cnt_next = '0;
                  if (words_loaded_reg != WORDS_MAX) begin
                     words_loaded_next = words_loaded_reg + 1'b1;
                  end
               end else begin
                  asm_next      = {asm_reg[15:0], bus.ld_data};
                  byte_cnt_next = byte_cnt_reg + 1'b1;
               end
            end
         end

         RUN: begin
            if (inst_reg[31:24] == OP_HALT) begin
               // pc stays on the HALT word; decoder sees NOPs from here on.
               state_next = HALT;
               inst_next  = '0;
            end else begin
               pc_next   = next_pc;
               inst_next = rd_data;
            end
         end

         default: begin
            state_next = IDLE;
            inst_next  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg        <= IDLE;
         pc_reg           <= '0;
         inst_reg         <= '0;
         asm_reg          <= '0;
         byte_cnt_reg     <= '0;
         wr_addr_reg      <= '0;
         words_loaded_reg <= '0;
      end else begin
         state_reg        <= state_next;
         pc_reg           <= pc_next;
         inst_reg         <= inst_next;
         asm_reg          <= asm_next;
         byte_cnt_reg     <= byte_cnt_next;
         wr_addr_reg      <= wr_addr_next;
         words_loaded_reg <= words_loaded_next;
      end
   end

   assign bus.ld_ready     = ld_ready;
   assign bus.inst         = inst_reg;
   assign bus.pc           = pc_reg;
   assign bus.running      = (state_reg == RUN);
   assign bus.halted       = (state_reg == HALT);
   assign bus.words_loaded = words_loaded_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed load/jump/halt/reset
// scenarios followed by randomized traffic, every cycle compared against a
// behavioural model (byte queue, word array, plain PC arithmetic).
module tb_fetch_unit;

   localparam int AW    = 6;
   localparam int DEPTH = 64;
   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_HALT = 2;

   logic clk;
   logic rst;

   fetch_unit_if #(.ADDR_W(AW)) bus ();

   fetch_unit #(.ADDR_W(AW), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- reference model ----------------
   logic [31:0] model_mem [DEPTH];
   bit   [7:0]  byte_q [$];
   int          mst;
   int          mpc;
   int          mwords;
   int          mwaddr;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      mst    = M_IDLE;
      mpc    = 0;
      mwords = 0;
      mwaddr = 0;
      byte_q.delete();
   endtask

   // Advance the model by one clock using the inputs currently on the bus.
   task automatic model_step();
      logic [31:0] w;
      case (mst)
         M_IDLE, M_HALT: begin
            if (bus.start) begin
               mst = M_RUN;
               mpc = 0;
               byte_q.delete();
            end else if (bus.ld_valid) begin
               if (mst == M_HALT) begin
                  mst    = M_IDLE;
                  mwaddr = 0;
                  mwords = 0;
                  byte_q.delete();
                  byte_q.push_back(bus.ld_data);
               end else begin
                  byte_q.push_back(bus.ld_data);
                  if (byte_q.size() == 4) begin
                     w = {byte_q[0], byte_q[1], byte_q[2], byte_q[3]};
                     model_mem[mwaddr] = w;
                     mwaddr = (mwaddr + 1) % DEPTH;
                     if (mwords < DEPTH) mwords = mwords + 1;
                     byte_q.delete();
                  end
               end
            end
         end
         default: begin
            w = model_mem[mpc];
            if (w[31:24] == 8'hFF) begin
               mst = M_HALT;
            end else if (bus.jmp_sig || (bus.jmp_sig_c && bus.flag)) begin
               mpc = int'(bus.jmp_add);
            end else begin
               mpc = (mpc + 1) % DEPTH;
            end
         end
      endcase
   endtask

   task automatic compare_all();
      logic [31:0] exp_inst;
      exp_inst = (mst == M_RUN) ? model_mem[mpc] : 32'h0;
      chk("pc",           64'(bus.pc),           64'(mpc));
      chk("inst",         64'(bus.inst),         64'(exp_inst));
      chk("running",      64'(bus.running),      64'(mst == M_RUN));
      chk("halted",       64'(bus.halted),       64'(mst == M_HALT));
      chk("words_loaded", 64'(bus.words_loaded), 64'(mwords));
      chk("ld_ready",     64'(bus.ld_ready),     64'((mst != M_RUN) && !bus.start));
   endtask

   // Called at (posedge + 1); leaves time at the next (posedge + 1).
   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic clear_inputs();
      bus.ld_valid  = 1'b0;
      bus.ld_data   = 8'h00;
      bus.start     = 1'b0;
      bus.jmp_sig   = 1'b0;
      bus.jmp_sig_c = 1'b0;
      bus.jmp_add   = '0;
      bus.flag      = 1'b0;
   endtask

   // Asynchronous reset asserted mid-cycle, checked before any clock edge.
   task automatic do_reset();
      clear_inputs();
      rst = 1'b1;
      #1;
      model_reset();
      compare_all();
      @(posedge clk);
      #1;
      rst = 1'b0;
      compare_all();
   endtask

   task automatic send_byte(input logic [7:0] b);
      bus.ld_valid = 1'b1;
      bus.ld_data  = b;
      tick();
      bus.ld_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int k = 3; k >= 0; k--) send_byte(w[8*k +: 8]);
      $display("load word %08h -> words_loaded %0d", w, bus.words_loaded);
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic jump(input logic u, input logic c, input logic f, input int target);
      bus.jmp_sig   = u;
      bus.jmp_sig_c = c;
      bus.flag      = f;
      bus.jmp_add   = AW'(target);
      tick();
      bus.jmp_sig   = 1'b0;
      bus.jmp_sig_c = 1'b0;
      bus.flag      = 1'b0;
      bus.jmp_add   = '0;
   endtask

   initial begin
      logic [31:0] w;
      rst = 1'b0;
      clear_inputs();
      model_reset();
      @(posedge clk);
      #1;
      do_reset();
      $display("reset state checked");

      // 65 words: fills all of memory, then overwrites word 0 with saturation.
      for (int i = 0; i < DEPTH + 1; i++) begin
         w = $urandom();
         w[31:24] = 8'($urandom_range(0, 254));
         send_word(w);
      end
      chk("words_sat", 64'(bus.words_loaded), 64'(64));
      pulse_start();
      repeat (70) tick();
      $display("straight-line run with pc wrap done");

      // Directed program.
      do_reset();
      send_word(32'h01000201);
      send_word(32'h10035500);
      chk("words_two", 64'(bus.words_loaded), 64'(2));
      send_word(32'h20000005);
      send_word(32'h21000000);
      send_word(32'hFF000000);
      pulse_start();
      chk("first_inst", 64'(bus.inst), 64'(32'h01000201));
      tick();
      chk("second_inst", 64'(bus.inst), 64'(32'h10035500));
      tick();
      jump(1'b1, 1'b0, 1'b0, 5);
      chk("jmp_pc", 64'(bus.pc), 64'(5));
      jump(1'b1, 1'b0, 1'b0, 3);
      jump(1'b0, 1'b1, 1'b0, 0);
      chk("jmpc_not_taken", 64'(bus.pc), 64'(4));
      tick();
      chk("halt_flag", 64'(bus.halted), 64'(1));
      tick();
      pulse_start();
      repeat (3) tick();
      jump(1'b0, 1'b1, 1'b1, 0);
      chk("jmpc_taken", 64'(bus.pc), 64'(0));
      jump(1'b1, 1'b1, 1'b1, 7);
      chk("both_jumps", 64'(bus.pc), 64'(7));
      $display("jump and halt sequence done");

      // Halt, then a loader byte restarts loading at word 0.
      jump(1'b1, 1'b0, 1'b0, 4);
      tick();
      send_word(32'hA1B2C3D4);
      chk("reload_words", 64'(bus.words_loaded), 64'(1));

      // Reset mid-word, then a partial word discarded by start.
      send_byte(8'h77);
      send_byte(8'h66);
      do_reset();
      send_word(32'h11223344);
      send_byte(8'hDE);
      send_byte(8'hAD);
      send_byte(8'hBE);
      pulse_start();
      chk("partial_discard", 64'(bus.inst), 64'(32'h11223344));
      $display("reset and partial-word cases done");

      // Randomized traffic.
      for (int i = 0; i < 1500; i++) begin
         bus.start     = ($urandom_range(0, 31) == 0);
         bus.ld_valid  = $urandom_range(0, 1) == 1;
         bus.ld_data   = 8'($urandom());
         bus.jmp_sig   = ($urandom_range(0, 7) == 0);
         bus.jmp_sig_c = ($urandom_range(0, 3) == 0);
         bus.flag      = $urandom_range(0, 1) == 1;
         bus.jmp_add   = AW'($urandom());
         tick();
      end
      clear_inputs();
      $display("random traffic done");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
